// File: rtl/perip_regfile.sv
// perip_regfile
//   Register file shared between the system bus and one peripheral core.
//   Each register can be bus-writable or read-only to the bus (ALLOW_WRITE).
//   Each register can be a plain register or a write-1-to-clear status
//   register (W1C_MASK). The bus side uses a req/gnt/rvalid handshake and
//   returns a registered response. The peripheral side has a write strobe
//   and a combinational read port.
//
//   Optional macro: PERIP_REGFILE_ERR_EN
//     When defined, bus_err_o is added. It is asserted together with
//     bus_rvalid_o when the granted access is out of range, or when it is a
//     write to a register the bus is not allowed to write.
//
// Ports
//   clk_i, rst_i       clock; synchronous active-high reset
//   bus_req_i          bus access request
//   bus_we_i           1 = write, 0 = read
//   bus_be_i           byte enables for writes
//   bus_addr_i         byte address; word index = addr >> log2(DATA_W/8)
//   bus_wdata_i        bus write data (W1C: 1 bits clear)
//   bus_gnt_o          request accepted this cycle (combinational)
//   bus_rvalid_o       one-cycle response pulse per granted access
//   bus_rdata_o        read data, valid with bus_rvalid_o (0 for writes)
//   perip_we_i         peripheral write strobe
//   perip_wraddr_i     peripheral write byte address
//   perip_wdata_i      peripheral write data (W1C: OR-set mask)
//   perip_rdaddr_i     peripheral read byte address
//   perip_rdata_o      combinational read of committed register state
//   bus_wr_pulse_o     bit i pulses the cycle after a committed bus write
//   bus_err_o          (PERIP_REGFILE_ERR_EN only) error response flag
module perip_regfile #(
    parameter int unsigned         NUM_REGS    = 10,
    parameter int unsigned         DATA_W      = 32,
    parameter logic [NUM_REGS-1:0] ALLOW_WRITE = '1,
    parameter logic [NUM_REGS-1:0] W1C_MASK    = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bus_req_i,
    input  logic                  bus_we_i,
    input  logic [DATA_W/8-1:0]   bus_be_i,
    input  logic [31:0]           bus_addr_i,
    input  logic [DATA_W-1:0]     bus_wdata_i,
    output logic                  bus_gnt_o,
    output logic                  bus_rvalid_o,
    output logic [DATA_W-1:0]     bus_rdata_o,
    input  logic                  perip_we_i,
    input  logic [31:0]           perip_wraddr_i,
    input  logic [DATA_W-1:0]     perip_wdata_i,
    input  logic [31:0]           perip_rdaddr_i,
    output logic [DATA_W-1:0]     perip_rdata_o,
    output logic [NUM_REGS-1:0]   bus_wr_pulse_o
`ifdef PERIP_REGFILE_ERR_EN
    ,
    output logic                  bus_err_o
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned OFF  = $clog2(BE_W);

    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("perip_regfile: NUM_REGS must be in 1..256");
    end
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("perip_regfile: DATA_W must be 32 or 64");
    end

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic [31:0]         w_bus_idx;
    logic [31:0]         w_pw_idx;
    logic [31:0]         w_pr_idx;
    logic                w_gnt;
    logic                w_bus_allow;
    logic                w_bus_wr;
    logic [DATA_W-1:0]   w_bus_rd;
    logic [DATA_W-1:0]   w_perip_rd;
    logic [DATA_W-1:0]   w_be_mask;
    logic [NUM_REGS-1:0] w_bus_hit;
    logic [NUM_REGS-1:0] w_pw_hit;
    logic [DATA_W-1:0]   w_next [NUM_REGS];

    assign w_bus_idx = bus_addr_i >> OFF;
    assign w_pw_idx  = perip_wraddr_i >> OFF;
    assign w_pr_idx  = perip_rdaddr_i >> OFF;
    assign w_gnt     = bus_req_i & ~rst_i;

    // Read muxes; an index that matches no register leaves the value at 0,
    // which covers out-of-range addresses. w_bus_allow is likewise 0 there.
    always_comb begin
        w_bus_rd    = '0;
        w_perip_rd  = '0;
        w_bus_allow = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_bus_idx == i) begin
                w_bus_rd    = r_regs[i];
                w_bus_allow = ALLOW_WRITE[i];
            end
            if (w_pr_idx == i) begin
                w_perip_rd = r_regs[i];
            end
        end
    end

    always_comb begin
        w_be_mask = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            w_be_mask[b*8 +: 8] = {8{bus_be_i[b]}};
        end
    end

    assign w_bus_wr = w_gnt & bus_we_i & w_bus_allow;

    // Peripheral update is applied first, bus update second: for a plain
    // register bus-enabled bytes override the peripheral word; for W1C the
    // order is reversed so a hardware set beats a same-cycle bus clear.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_bus_hit[i] = w_bus_wr && (w_bus_idx == i);
            w_pw_hit[i]  = perip_we_i && (w_pw_idx == i);
            w_next[i]    = r_regs[i];
            if (W1C_MASK[i]) begin
                if (w_bus_hit[i]) begin
                    w_next[i] = w_next[i] & ~(bus_wdata_i & w_be_mask);
                end
                if (w_pw_hit[i]) begin
                    w_next[i] = w_next[i] | perip_wdata_i;
                end
            end else begin
                if (w_pw_hit[i]) begin
                    w_next[i] = perip_wdata_i;
                end
                if (w_bus_hit[i]) begin
                    w_next[i] = (w_next[i] & ~w_be_mask) | (bus_wdata_i & w_be_mask);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_next[i];
            end
            r_rvalid   <= w_gnt;
            r_rdata    <= (w_gnt && !bus_we_i) ? w_bus_rd : '0;
            r_wr_pulse <= (|bus_be_i) ? w_bus_hit : '0;
        end
    end

`ifdef PERIP_REGFILE_ERR_EN
    logic r_err;
    logic w_bus_in;

    assign w_bus_in = (w_bus_idx < NUM_REGS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_gnt & (~w_bus_in | (bus_we_i & ~w_bus_allow));
        end
    end

    assign bus_err_o = r_err;
`endif

    assign bus_gnt_o      = w_gnt;
    assign bus_rvalid_o   = r_rvalid;
    assign bus_rdata_o    = r_rdata;
    assign perip_rdata_o  = w_perip_rd;
    assign bus_wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_perip_regfile.sv
// Directed bench for perip_regfile: 10 x 32-bit, register 2 is W1C,
// register 3 is read-only to the bus.
module tb_perip_regfile;

    localparam int unsigned NR = 10;
    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          bus_req_i;
    logic          bus_we_i;
    logic [3:0]    bus_be_i;
    logic [31:0]   bus_addr_i;
    logic [31:0]   bus_wdata_i;
    logic          bus_gnt_o;
    logic          bus_rvalid_o;
    logic [31:0]   bus_rdata_o;
    logic          perip_we_i;
    logic [31:0]   perip_wraddr_i;
    logic [31:0]   perip_wdata_i;
    logic [31:0]   perip_rdaddr_i;
    logic [31:0]   perip_rdata_o;
    logic [NR-1:0] bus_wr_pulse_o;
    logic          bus_err_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // response captured by bus_access
    logic          s_gnt;
    logic          s_rvalid;
    logic [31:0]   s_rdata;
    logic [NR-1:0] s_pulse;
    logic          s_err;

    perip_regfile #(
        .NUM_REGS    (NR),
        .DATA_W      (DW),
        .ALLOW_WRITE (10'h3F7),
        .W1C_MASK    (10'h004),
        .RESET_VAL   (32'h0)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bus_req_i      (bus_req_i),
        .bus_we_i       (bus_we_i),
        .bus_be_i       (bus_be_i),
        .bus_addr_i     (bus_addr_i),
        .bus_wdata_i    (bus_wdata_i),
        .bus_gnt_o      (bus_gnt_o),
        .bus_rvalid_o   (bus_rvalid_o),
        .bus_rdata_o    (bus_rdata_o),
        .perip_we_i     (perip_we_i),
        .perip_wraddr_i (perip_wraddr_i),
        .perip_wdata_i  (perip_wdata_i),
        .perip_rdaddr_i (perip_rdaddr_i),
        .perip_rdata_o  (perip_rdata_o),
        .bus_wr_pulse_o (bus_wr_pulse_o)
`ifdef PERIP_REGFILE_ERR_EN
        ,
        .bus_err_o      (bus_err_o)
`endif
    );

`ifndef PERIP_REGFILE_ERR_EN
    assign bus_err_o = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge. Presents one bus access,
    // samples gnt before the edge and the response 1 unit after it.
    task automatic bus_access(input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bus_req_i   = 1'b1;
        bus_we_i    = we;
        bus_be_i    = be;
        bus_addr_i  = addr;
        bus_wdata_i = wdata;
        #1;
        s_gnt = bus_gnt_o;
        @(posedge clk_i);
        #1;
        bus_req_i = 1'b0;
        bus_we_i  = 1'b0;
        bus_be_i  = 4'h0;
        s_rvalid  = bus_rvalid_o;
        s_rdata   = bus_rdata_o;
        s_pulse   = bus_wr_pulse_o;
        s_err     = bus_err_o;
    endtask

    task automatic perip_write(input logic [31:0] addr, input logic [31:0] data);
        perip_we_i     = 1'b1;
        perip_wraddr_i = addr;
        perip_wdata_i  = data;
        @(posedge clk_i);
        #1;
        perip_we_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i          = 1'b1;
        bus_req_i      = 1'b0;
        bus_we_i       = 1'b0;
        bus_be_i       = 4'h0;
        bus_addr_i     = 32'h0;
        bus_wdata_i    = 32'h0;
        perip_we_i     = 1'b0;
        perip_wraddr_i = 32'h0;
        perip_wdata_i  = 32'h0;
        perip_rdaddr_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        check("rst_rvalid", 64'(bus_rvalid_o), 64'h0);
        check("rst_rdata", 64'(bus_rdata_o), 64'h0);
        check("rst_pulse", 64'(bus_wr_pulse_o), 64'h0);
        check("rst_prdata", 64'(perip_rdata_o), 64'h0);

        // read after reset
        bus_access(1'b0, 4'h0, 32'h8, 32'h0);
        check("rd8_gnt", 64'(s_gnt), 64'h1);
        check("rd8_rvalid", 64'(s_rvalid), 64'h1);
        check("rd8_rdata", 64'(s_rdata), 64'h0);
        idle_cycle();
        check("idle_rvalid", 64'(bus_rvalid_o), 64'h0);

        // partial byte write onto 0x11223344
        perip_write(32'h4, 32'h11223344);
        perip_rdaddr_i = 32'h4;
        #1;
        check("p_rd1", 64'(perip_rdata_o), 64'h11223344);
        bus_access(1'b1, 4'b0101, 32'h4, 32'hAABBCCDD);
        check("wr1_rvalid", 64'(s_rvalid), 64'h1);
        check("wr1_rdata", 64'(s_rdata), 64'h0);
        check("wr1_pulse", 64'(s_pulse), 64'h002);
        check("wr1_err", 64'(s_err), 64'h0);
        idle_cycle();
        check("wr1_pulse_clr", 64'(bus_wr_pulse_o), 64'h0);
        bus_access(1'b0, 4'h0, 32'h4, 32'h0);
        check("rd1_after_wr", 64'(s_rdata), 64'h11BB33DD);

        // W1C register 2
        perip_write(32'h8, 32'h0000000F);
        bus_access(1'b1, 4'hF, 32'h8, 32'h00000005);
        check("w1c_pulse", 64'(s_pulse), 64'h004);
        bus_access(1'b0, 4'h0, 32'h8, 32'h0);
        check("w1c_clear", 64'(s_rdata), 64'h0000000A);
        // all byte enables low: no effect, no pulse
        bus_access(1'b1, 4'h0, 32'h8, 32'hFFFFFFFF);
        check("be0_rvalid", 64'(s_rvalid), 64'h1);
        check("be0_pulse", 64'(s_pulse), 64'h0);
        // hardware set beats bus clear on the same bit
        perip_we_i     = 1'b1;
        perip_wraddr_i = 32'h8;
        perip_wdata_i  = 32'h00000001;
        bus_access(1'b1, 4'hF, 32'h8, 32'h00000001);
        perip_we_i = 1'b0;
        // back-to-back reads of reg2 then reg1
        bus_access(1'b0, 4'h0, 32'h8, 32'h0);
        check("w1c_collide", 64'(s_rdata), 64'h0000000B);
        bus_access(1'b0, 4'h0, 32'h4, 32'h0);
        check("b2b_rvalid", 64'(s_rvalid), 64'h1);
        check("b2b_rdata", 64'(s_rdata), 64'h11BB33DD);

        // read-only register 3 (peripheral writes still land)
        perip_write(32'hC, 32'h00000055);
        bus_access(1'b1, 4'hF, 32'hC, 32'hFFFFFFFF);
        check("ro_rvalid", 64'(s_rvalid), 64'h1);
        check("ro_pulse", 64'(s_pulse), 64'h0);
`ifdef PERIP_REGFILE_ERR_EN
        check("ro_err", 64'(s_err), 64'h1);
`endif
        bus_access(1'b0, 4'h0, 32'hC, 32'h0);
        check("ro_unchanged", 64'(s_rdata), 64'h00000055);
`ifdef PERIP_REGFILE_ERR_EN
        check("ro_rd_err", 64'(s_err), 64'h0);
`endif

        // same-cycle collision on plain register 0
        perip_we_i     = 1'b1;
        perip_wraddr_i = 32'h0;
        perip_wdata_i  = 32'h12345678;
        bus_access(1'b1, 4'b1000, 32'h0, 32'hAB000000);
        perip_we_i = 1'b0;
        check("col_pulse", 64'(s_pulse), 64'h001);
        perip_rdaddr_i = 32'h0;
        #1;
        check("col_prdata", 64'(perip_rdata_o), 64'hAB345678);
        // bus read returns the value before a same-cycle peripheral write
        perip_we_i     = 1'b1;
        perip_wraddr_i = 32'h0;
        perip_wdata_i  = 32'h00000001;
        bus_access(1'b0, 4'h0, 32'h0, 32'h0);
        perip_we_i = 1'b0;
        check("read_old", 64'(s_rdata), 64'hAB345678);
        check("p_rd0_new", 64'(perip_rdata_o), 64'h00000001);

        // out of range
        bus_access(1'b0, 4'h0, 32'h28, 32'h0);
        check("oor_rvalid", 64'(s_rvalid), 64'h1);
        check("oor_rdata", 64'(s_rdata), 64'h0);
`ifdef PERIP_REGFILE_ERR_EN
        check("oor_err", 64'(s_err), 64'h1);
`endif
        bus_access(1'b1, 4'hF, 32'h28, 32'hDEADBEEF);
        check("oor_wr_pulse", 64'(s_pulse), 64'h0);
        perip_rdaddr_i = 32'h28;
        #1;
        check("oor_prdata", 64'(perip_rdata_o), 64'h0);

        // request during reset: no grant, no response, state cleared
        rst_i = 1'b1;
        bus_access(1'b0, 4'h0, 32'h4, 32'h0);
        check("rst_gnt", 64'(s_gnt), 64'h0);
        check("rst_no_rvalid", 64'(s_rvalid), 64'h0);
        rst_i = 1'b0;
        idle_cycle();
        check("rst_no_rvalid2", 64'(bus_rvalid_o), 64'h0);
        bus_access(1'b0, 4'h0, 32'h4, 32'h0);
        check("rst_reg1", 64'(s_rdata), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
